// File: rtl/pg_tx_wrr_arbiter.sv
// pg_tx_wrr_arbiter
//   Packet-atomic weighted round-robin arbiter for the port-gasket TX path.
//   Merges NUM_PORT per-function AXI-S TX requesters onto one TX channel
//   through a one-deep registered output stage. Once a port is granted,
//   its packet runs to tlast without interleave. A port that falls into
//   reset mid-packet gets its packet closed with a zero tlast beat.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   port_rst_n          per-port active-low reset (synchronous to clk)
//   cfg_weight          per-port weight = packets per turn, 0 disables the port
//   in_t*               per-port AXI-S slave inputs, port i at slice i
//   out_t*, out_port    merged AXI-S master output and its source port
//   err_abort           one-cycle pulse when a packet is force-closed
//   err_abort_sticky    abort seen since rst_n
//
// Optional feature (macro PG_TX_ARB_STATS_EN)
//   stat_beats, stat_pkts: per-port 32-bit wrapping counters of beats and
//   tlast beats loaded into the output register.
module pg_tx_wrr_arbiter #(
    parameter int NUM_PORT    = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10,
    parameter int WEIGHT_W    = 4,
    localparam int PORT_W     = $clog2(NUM_PORT)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORT-1:0]             port_rst_n,
    input  logic [NUM_PORT*WEIGHT_W-1:0]    cfg_weight,
    input  logic [NUM_PORT-1:0]             in_tvalid,
    output logic [NUM_PORT-1:0]             in_tready,
    input  logic [NUM_PORT-1:0]             in_tlast,
    input  logic [NUM_PORT*TDATA_WIDTH-1:0] in_tdata,
    input  logic [NUM_PORT*TUSER_WIDTH-1:0] in_tuser,
    output logic                            out_tvalid,
    input  logic                            out_tready,
    output logic                            out_tlast,
    output logic [TDATA_WIDTH-1:0]          out_tdata,
    output logic [TUSER_WIDTH-1:0]          out_tuser,
    output logic [PORT_W-1:0]               out_port,
    output logic                            err_abort,
    output logic                            err_abort_sticky
`ifdef PG_TX_ARB_STATS_EN
    ,
    output logic [NUM_PORT*32-1:0]          stat_beats,
    output logic [NUM_PORT*32-1:0]          stat_pkts
`endif
);

    typedef enum logic [1:0] {IDLE, LOCK, CLOSE} state_t;

    state_t               state_q, state_d;
    logic [PORT_W-1:0]    lock_q, lock_d;
    logic [PORT_W-1:0]    rr_q, rr_d;
    logic                 in_pkt_q, in_pkt_d;   // >=1 beat of the locked packet sent
    logic [WEIGHT_W-1:0]  credit_q [NUM_PORT];
    logic [WEIGHT_W-1:0]  credit_d [NUM_PORT];

    logic [WEIGHT_W-1:0]    port_weight [NUM_PORT];
    logic [TDATA_WIDTH-1:0] port_tdata  [NUM_PORT];
    logic [TUSER_WIDTH-1:0] port_tuser  [NUM_PORT];
    logic [NUM_PORT-1:0]    eligible;

    logic                 adv;
    logic                 accept;
    logic                 load_beat;
    logic                 load_close;
    logic                 pick_found;
    logic [PORT_W-1:0]    pick_port;
    logic [PORT_W-1:0]    scan_idx;

    function automatic logic [PORT_W-1:0] wrap_inc(input logic [PORT_W-1:0] p);
        return (int'(p) == NUM_PORT - 1) ? '0 : p + 1'b1;
    endfunction

    assign adv    = !out_tvalid || out_tready;
    assign accept = (state_q == LOCK) && adv && in_tvalid[lock_q];

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            port_weight[i] = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
            port_tdata[i]  = in_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
            port_tuser[i]  = in_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
            eligible[i]    = in_tvalid[i] && port_rst_n[i] && (port_weight[i] != '0);
        end
    end

    // Ready is a function of the lock and the output stage only, never of
    // the requester's own tvalid.
    always_comb begin
        in_tready = '0;
        if (state_q == LOCK && adv) in_tready[lock_q] = 1'b1;
    end

    // First eligible port at or after rr_q. Scanning from the far end lets
    // the last hit (the nearest one) win without a priority chain.
    always_comb begin
        pick_found = 1'b0;
        pick_port  = '0;
        scan_idx   = '0;
        for (int k = NUM_PORT - 1; k >= 0; k--) begin
            scan_idx = PORT_W'((int'(rr_q) + k) % NUM_PORT);
            if (eligible[scan_idx]) begin
                pick_found = 1'b1;
                pick_port  = scan_idx;
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch; blocking '=' is correct here
    // because this block models wires, not state.
    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        rr_d       = rr_q;
        in_pkt_d   = in_pkt_q;
        credit_d   = credit_q;
        load_beat  = 1'b0;
        load_close = 1'b0;
        case (state_q)
            IDLE: begin
                // Leftover credit on a port that went quiet ends its turn.
                if (credit_q[rr_q] != '0 && !eligible[rr_q]) credit_d[rr_q] = '0;
                if (pick_found) begin
                    state_d  = LOCK;
                    lock_d   = pick_port;
                    in_pkt_d = 1'b0;
                    if (credit_q[pick_port] == '0) credit_d[pick_port] = port_weight[pick_port];
                end
            end
            LOCK: begin
                if (accept) begin
                    load_beat = 1'b1;
                    if (in_tlast[lock_q]) begin
                        // A completed packet wins over a simultaneous port reset.
                        state_d  = IDLE;
                        in_pkt_d = 1'b0;
                        if (credit_q[lock_q] <= WEIGHT_W'(1)) begin
                            credit_d[lock_q] = '0;
                            rr_d             = wrap_inc(lock_q);
                        end else begin
                            credit_d[lock_q] = credit_q[lock_q] - 1'b1;
                            rr_d             = lock_q;
                        end
                    end else begin
                        in_pkt_d = 1'b1;
                        if (!port_rst_n[lock_q]) state_d = CLOSE;
                    end
                end else if (!port_rst_n[lock_q]) begin
                    if (in_pkt_q) begin
                        state_d = CLOSE;
                    end else begin
                        // Nothing sent yet: release the lock without an abort.
                        state_d          = IDLE;
                        credit_d[lock_q] = '0;
                    end
                end
            end
            CLOSE: begin
                if (adv) begin
                    load_close       = 1'b1;
                    state_d          = IDLE;
                    in_pkt_d         = 1'b0;
                    credit_d[lock_q] = '0;
                    rr_d             = wrap_inc(lock_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the credit array is reset with the rest of the state because
    // IDLE reads it before any write; a stale credit would skip a reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lock_q   <= '0;
            rr_q     <= '0;
            in_pkt_q <= 1'b0;
            for (int i = 0; i < NUM_PORT; i++) credit_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            rr_q     <= rr_d;
            in_pkt_q <= in_pkt_d;
            credit_q <= credit_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_tvalid       <= 1'b0;
            out_tlast        <= 1'b0;
            out_tdata        <= '0;
            out_tuser        <= '0;
            out_port         <= '0;
            err_abort        <= 1'b0;
            err_abort_sticky <= 1'b0;
        end else begin
            if (load_beat) begin
                out_tvalid <= 1'b1;
                out_tlast  <= in_tlast[lock_q];
                out_tdata  <= port_tdata[lock_q];
                out_tuser  <= port_tuser[lock_q];
                out_port   <= lock_q;
            end else if (load_close) begin
                out_tvalid <= 1'b1;
                out_tlast  <= 1'b1;
                out_tdata  <= '0;
                out_tuser  <= '0;
                out_port   <= lock_q;
            end else if (adv) begin
                out_tvalid <= 1'b0;
            end
            err_abort        <= load_close;
            err_abort_sticky <= err_abort_sticky | load_close;
        end
    end

`ifdef PG_TX_ARB_STATS_EN
    logic [31:0] beats_q [NUM_PORT];
    logic [31:0] pkts_q  [NUM_PORT];

    // The forced close beat occupies the output register, so it counts as a
    // beat, but it does not complete a real packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORT; i++) begin
                beats_q[i] <= '0;
                pkts_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORT; i++) begin
                if ((load_beat || load_close) && lock_q == PORT_W'(i))
                    beats_q[i] <= beats_q[i] + 32'd1;
                if (load_beat && in_tlast[lock_q] && lock_q == PORT_W'(i))
                    pkts_q[i] <= pkts_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        stat_beats = '0;
        stat_pkts  = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            stat_beats[i*32 +: 32] = beats_q[i];
            stat_pkts[i*32 +: 32]  = pkts_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_pg_tx_wrr_arbiter.sv
// tb_pg_tx_wrr_arbiter
//   Directed bench for pg_tx_wrr_arbiter (4 ports, default widths).
//   Per-port packet sources are bench queues; every out beat is compared
//   against a hand-built expected sequence on every cycle it is presented.
module tb_pg_tx_wrr_arbiter;

    localparam int NP = 4;
    localparam int DW = 512;
    localparam int UW = 10;
    localparam int WW = 4;
    localparam int PW = 2;

    typedef struct packed {
        logic [PW-1:0] port;
        logic          last;
        logic [DW-1:0] data;
        logic [UW-1:0] user;
    } beat_t;

    localparam int BW = $bits(beat_t);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    port_rst_n;
    logic [NP*WW-1:0] cfg_weight;
    logic [NP-1:0]    in_tvalid;
    logic [NP-1:0]    in_tready;
    logic [NP-1:0]    in_tlast;
    logic [NP*DW-1:0] in_tdata;
    logic [NP*UW-1:0] in_tuser;
    logic             out_tvalid;
    logic             out_tready;
    logic             out_tlast;
    logic [DW-1:0]    out_tdata;
    logic [UW-1:0]    out_tuser;
    logic [PW-1:0]    out_port;
    logic             err_abort;
    logic             err_abort_sticky;
`ifdef PG_TX_ARB_STATS_EN
    logic [NP*32-1:0] stat_beats;
    logic [NP*32-1:0] stat_pkts;
`endif

    pg_tx_wrr_arbiter #(
        .NUM_PORT(NP), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .WEIGHT_W(WW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .port_rst_n(port_rst_n), .cfg_weight(cfg_weight),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
        .in_tdata(in_tdata), .in_tuser(in_tuser),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .out_tdata(out_tdata), .out_tuser(out_tuser), .out_port(out_port),
        .err_abort(err_abort), .err_abort_sticky(err_abort_sticky)
`ifdef PG_TX_ARB_STATS_EN
        , .stat_beats(stat_beats), .stat_pkts(stat_pkts)
`endif
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t src_q [NP][$];
    logic [NP-1:0] src_en;
    beat_t exp_q [$];
    bit    exp_en = 1'b0;
    bit    toggle_ready = 1'b0;
    int    obs_cnt = 0;
    int    hs_cnt [NP];
    int    abort_pulses = 0;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int p, input int s, input logic l);
        logic [UW-1:0] tag;
        beat_t b;
        tag    = UW'(p * 64 + s);
        b.port = PW'(p);
        b.last = l;
        b.data = {16{16'hC0DE, 6'd0, tag}};
        b.user = tag;
        return b;
    endfunction

    task automatic push_pkt(input int p, input int s0, input int len);
        for (int j = 0; j < len; j++) src_q[p].push_back(mk_beat(p, s0 + j, j == len - 1));
    endtask

    task automatic drive_ports();
        for (int i = 0; i < NP; i++) begin
            if (src_en[i] && src_q[i].size() > 0) begin
                in_tvalid[i]           = 1'b1;
                in_tlast[i]            = src_q[i][0].last;
                in_tdata[i*DW +: DW]   = src_q[i][0].data;
                in_tuser[i*UW +: UW]   = src_q[i][0].user;
            end else begin
                in_tvalid[i]           = 1'b0;
                in_tlast[i]            = 1'b0;
                in_tdata[i*DW +: DW]   = '0;
                in_tuser[i*UW +: UW]   = '0;
            end
        end
    endtask

    // One clock: checks the presented out beat before the edge, then after
    // the edge retires input handshakes and checks 1-cycle latency.
    task automatic tick();
        logic [NP-1:0] hs;
        logic          out_hs;
        beat_t         hs_beat;
        int            hs_port;
        #1;
        hs      = in_tvalid & in_tready;
        out_hs  = out_tvalid && out_tready;
        hs_port = -1;
        hs_beat = '0;
        if (exp_en && out_tvalid) begin
            if (obs_cnt < exp_q.size())
                check($sformatf("beat%0d", obs_cnt),
                      beat_t'{out_port, out_tlast, out_tdata, out_tuser}, exp_q[obs_cnt]);
            else
                check("extra_beat_valid", out_tvalid, 1'b0);
        end
        for (int i = 0; i < NP; i++) begin
            if (hs[i]) begin
                hs_port = i;
                hs_beat = src_q[i][0];
            end
        end
        @(posedge clk);
        #1;
        if (out_hs) obs_cnt++;
        if (hs_port >= 0) begin
            void'(src_q[hs_port].pop_front());
            hs_cnt[hs_port]++;
            check("lat_valid", out_tvalid, 1'b1);
            check("lat_data", {out_tuser, out_tdata}, {hs_beat.user, hs_beat.data});
        end
        if (err_abort) abort_pulses++;
        if (toggle_ready) out_tready = !out_tready;
        drive_ports();
    endtask

    task automatic run_until_obs(input int n, input int budget);
        int c = 0;
        while (obs_cnt < n && c < budget) begin
            tick();
            c++;
        end
        check("obs_count", obs_cnt, n);
    endtask

    task automatic wait_hs(input int p, input int n, input int budget);
        int c = 0;
        while (hs_cnt[p] < n && c < budget) begin
            tick();
            c++;
        end
        check($sformatf("hs_count_p%0d", p), hs_cnt[p], n);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tvalid"}, out_tvalid, 1'b0);
        check({tag, "_tlast"}, out_tlast, 1'b0);
        check({tag, "_tdata_tuser"}, {out_tuser, out_tdata}, '0);
        check({tag, "_port"}, out_port, '0);
        check({tag, "_abort"}, {err_abort, err_abort_sticky}, '0);
        check({tag, "_in_tready"}, in_tready, '0);
    endtask

    task automatic do_reset(input logic [NP*WW-1:0] w);
        exp_en       = 1'b0;
        toggle_ready = 1'b0;
        rst_n        = 1'b0;
        out_tready   = 1'b1;
        port_rst_n   = '1;
        cfg_weight   = w;
        src_en       = '1;
        for (int i = 0; i < NP; i++) begin
            src_q[i].delete();
            hs_cnt[i] = 0;
        end
        drive_ports();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs_zero("rst");
        rst_n        = 1'b1;
        exp_q.delete();
        obs_cnt      = 0;
        abort_pulses = 0;
    endtask

    initial begin
        beat_t cb;
        rst_n      = 1'b0;
        out_tready = 1'b1;
        port_rst_n = '1;
        cfg_weight = '0;
        src_en     = '1;
        in_tvalid  = '0;
        in_tlast   = '0;
        in_tdata   = '0;
        in_tuser   = '0;

        // Equal weights, three single-beat packets per port: strict rotation.
        do_reset({4'd1, 4'd1, 4'd1, 4'd1});
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 3; k++) push_pkt(p, k, 1);
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < NP; p++) exp_q.push_back(mk_beat(p, k, 1'b1));
        exp_en = 1'b1;
        drive_ports();
        run_until_obs(12, 100);
        repeat (3) tick();
`ifdef PG_TX_ARB_STATS_EN
        for (int p = 0; p < NP; p++) begin
            check($sformatf("s1_pkts_p%0d", p), stat_pkts[p*32 +: 32], 32'd3);
            check($sformatf("s1_beats_p%0d", p), stat_beats[p*32 +: 32], 32'd3);
        end
`endif

        // Weights {3,1,0,2} saturated: rounds of 0,0,0,1,3,3; port 2 starves.
        do_reset({4'd2, 4'd0, 4'd1, 4'd3});
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 20; k++) push_pkt(p, k, 1);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) exp_q.push_back(mk_beat(0, 3 * r + k, 1'b1));
            exp_q.push_back(mk_beat(1, r, 1'b1));
            for (int k = 0; k < 2; k++) exp_q.push_back(mk_beat(3, 2 * r + k, 1'b1));
        end
        exp_en = 1'b1;
        drive_ports();
        run_until_obs(12, 200);
        exp_en = 1'b0;
        check("s2_port2_never", hs_cnt[2], 0);

        // 8-beat packet on port 1 with out_tready toggling: no interleave,
        // out_* held on stalled cycles (checked against the expected beat).
        do_reset({4'd1, 4'd1, 4'd1, 4'd1});
        push_pkt(0, 0, 1);
        push_pkt(1, 0, 8);
        push_pkt(0, 1, 1);
        exp_q.push_back(mk_beat(0, 0, 1'b1));
        for (int j = 0; j < 8; j++) exp_q.push_back(mk_beat(1, j, j == 7));
        exp_q.push_back(mk_beat(0, 1, 1'b1));
        exp_en       = 1'b1;
        toggle_ready = 1'b1;
        drive_ports();
        run_until_obs(10, 200);

        // Port 2 reset after 3 of 6 beats: forced close beat, abort, then port 3.
        do_reset({4'd1, 4'd1, 4'd1, 4'd1});
        push_pkt(2, 0, 6);
        push_pkt(3, 0, 1);
        for (int j = 0; j < 3; j++) exp_q.push_back(mk_beat(2, j, 1'b0));
        cb.port = 2'd2;
        cb.last = 1'b1;
        cb.data = '0;
        cb.user = '0;
        exp_q.push_back(cb);
        exp_q.push_back(mk_beat(3, 0, 1'b1));
        exp_en = 1'b1;
        drive_ports();
        wait_hs(2, 3, 50);
        port_rst_n[2] = 1'b0;
        src_en[2]     = 1'b0;
        src_q[2].delete();
        drive_ports();
        run_until_obs(5, 50);
        repeat (2) tick();
        check("s4_abort_pulses", abort_pulses, 1);
        check("s4_sticky", err_abort_sticky, 1'b1);
        check("s4_abort_low", err_abort, 1'b0);
`ifdef PG_TX_ARB_STATS_EN
        check("s4_pkts_p2", stat_pkts[2*32 +: 32], 32'd0);
        check("s4_beats_p2", stat_beats[2*32 +: 32], 32'd4);
        check("s4_pkts_p3", stat_pkts[3*32 +: 32], 32'd1);
`endif

        // rst_n mid-packet: outputs clear asynchronously, rr restarts at 0.
        do_reset({4'd1, 4'd1, 4'd1, 4'd1});
        push_pkt(2, 0, 1);
        exp_q.push_back(mk_beat(2, 0, 1'b1));
        exp_en = 1'b1;
        drive_ports();
        run_until_obs(1, 30);
        exp_en = 1'b0;
        push_pkt(1, 0, 6);
        drive_ports();
        wait_hs(1, 2, 30);
        check("s5_pre_rst_valid", out_tvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        for (int i = 0; i < NP; i++) begin
            src_q[i].delete();
            hs_cnt[i] = 0;
        end
        drive_ports();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        obs_cnt = 0;
        push_pkt(0, 0, 1);
        push_pkt(3, 0, 1);
        exp_q.push_back(mk_beat(0, 0, 1'b1));
        exp_q.push_back(mk_beat(3, 0, 1'b1));
        exp_en = 1'b1;
        drive_ports();
        run_until_obs(2, 30);
        exp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
